// File: rtl/dac_frame_sequencer.sv
// Stereo serial DAC frame sequencer: one frame per sample with bit clock,
// MSB-first left/right data and latch strobes, fed by a valid/ready handshake.
module dac_frame_sequencer #(
    parameter int DIV          = 4,
    parameter int FRAME_CYCLES = 1000,
    parameter int WIDTH        = 16
) (
    input  logic             clk_48,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             mute,
    input  logic [WIDTH-1:0] in_left,
    input  logic [WIDTH-1:0] in_right,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             bck,
    output logic             DL,
    output logic             DR,
    output logic             LL,
    output logic             LR,
    output logic             frame_start,
    output logic             busy,
    output logic             underrun,
    output logic [7:0]       underrun_cnt
);

    localparam int CYC_W  = $clog2(FRAME_CYCLES);
    localparam int SLOTS  = FRAME_CYCLES / DIV;
    localparam int SLOT_W = $clog2(SLOTS + 1);
    localparam int PH_W   = $clog2(DIV);

    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

    state_t            state_reg, state_next;
    logic [CYC_W-1:0]  cyc_reg;
    logic [PH_W-1:0]   phase_reg;
    logic [SLOT_W-1:0] slot_reg;
    logic              run, frame_end, capture, shift_en, data_slot;
    logic              bck_reg, latch_reg, frame_start_reg;
    logic              underrun_reg;
    logic [7:0]        underrun_cnt_reg;
    logic [1:0]        chan_bit;
    logic [WIDTH-1:0]  sample_in [2];

    assign sample_in[0] = in_left;
    assign sample_in[1] = in_right;

    assign run       = (state_reg == RUN);
    assign frame_end = run && (cyc_reg == CYC_W'(FRAME_CYCLES - 1));
    assign capture   = in_ready;
    assign shift_en  = run && (phase_reg == PH_W'(DIV - 1));
    assign data_slot = (slot_reg < SLOT_W'(WIDTH));

    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    // A stop request only takes effect at a frame boundary, so the frame
    // in flight always completes including its latch slot.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable) state_next = ARM;
            end
            ARM: begin
                busy       = 1'b1;
                in_ready   = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (frame_end) begin
                    if (enable) in_ready   = 1'b1;
                    else        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Phase and slot are counted alongside cyc to avoid a divider.
    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            cyc_reg   <= '0;
            phase_reg <= '0;
            slot_reg  <= '0;
        end else if (!run || frame_end) begin
            cyc_reg   <= '0;
            phase_reg <= '0;
            slot_reg  <= '0;
        end else begin
            cyc_reg <= cyc_reg + CYC_W'(1);
            if (phase_reg == PH_W'(DIV - 1)) begin
                phase_reg <= '0;
                slot_reg  <= slot_reg + SLOT_W'(1);
            end else begin
                phase_reg <= phase_reg + PH_W'(1);
            end
        end
    end

    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            underrun_reg     <= 1'b0;
            underrun_cnt_reg <= '0;
        end else if (capture && !in_valid) begin
            underrun_reg <= 1'b1;
            if (underrun_cnt_reg != 8'hFF) underrun_cnt_reg <= underrun_cnt_reg + 8'd1;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        logic [WIDTH-1:0] held_reg;
        logic [WIDTH-1:0] shift_reg;
        logic             data_reg;

        // Mute only blanks the shifter; the held sample still tracks input.
        always_ff @(posedge clk_48 or negedge reset_n) begin
            if (!reset_n) begin
                held_reg  <= '0;
                shift_reg <= '0;
                data_reg  <= 1'b0;
            end else begin
                if (capture) begin
                    if (in_valid) held_reg <= sample_in[gi];
                    shift_reg <= mute ? '0 : (in_valid ? sample_in[gi] : held_reg);
                end else if (shift_en) begin
                    shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                end
                data_reg <= run && data_slot && shift_reg[WIDTH-1];
            end
        end

        assign chan_bit[gi] = data_reg;
    end

    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            bck_reg         <= 1'b0;
            latch_reg       <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            bck_reg         <= run && (phase_reg >= PH_W'(DIV / 2));
            latch_reg       <= run && (slot_reg == SLOT_W'(WIDTH));
            frame_start_reg <= run && (cyc_reg == '0);
        end
    end

    assign bck          = bck_reg;
    assign DL           = chan_bit[0];
    assign DR           = chan_bit[1];
    assign LL           = latch_reg;
    assign LR           = latch_reg;
    assign frame_start  = frame_start_reg;
    assign underrun     = underrun_reg;
    assign underrun_cnt = underrun_cnt_reg;

endmodule

// File: tb/tb_dac_frame_sequencer.sv
// Directed bench for dac_frame_sequencer: default instance plus a DIV=2,
// FRAME_CYCLES=40 instance, checked against a sample scoreboard.
module tb_dac_frame_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en_a, en_b, mute, in_valid;
    logic [15:0] in_left, in_right;

    logic a_ready, a_bck, a_dl, a_dr, a_ll, a_lr, a_fs, a_busy, a_ur;
    logic b_ready, b_bck, b_dl, b_dr, b_ll, b_lr, b_fs, b_busy, b_ur;
    logic [7:0] a_cnt, b_cnt;

    logic sel = 1'b0;
    logic m_ready, m_bck, m_dl, m_dr, m_ll, m_lr, m_fs, m_busy, m_ur;
    logic [7:0] m_cnt;

    int passed = 0;
    int total  = 0;
    int fails  = 0;
    int div    = 4;
    int fc     = 1000;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] held_l, held_r;
    int          exp_cnt;

    always #5 clk = ~clk;

    dac_frame_sequencer u_a (
        .clk_48(clk), .reset_n(reset_n), .enable(en_a), .mute(mute),
        .in_left(in_left), .in_right(in_right), .in_valid(in_valid),
        .in_ready(a_ready), .bck(a_bck), .DL(a_dl), .DR(a_dr), .LL(a_ll), .LR(a_lr),
        .frame_start(a_fs), .busy(a_busy), .underrun(a_ur), .underrun_cnt(a_cnt)
    );

    dac_frame_sequencer #(.DIV(2), .FRAME_CYCLES(40), .WIDTH(16)) u_b (
        .clk_48(clk), .reset_n(reset_n), .enable(en_b), .mute(mute),
        .in_left(in_left), .in_right(in_right), .in_valid(in_valid),
        .in_ready(b_ready), .bck(b_bck), .DL(b_dl), .DR(b_dr), .LL(b_ll), .LR(b_lr),
        .frame_start(b_fs), .busy(b_busy), .underrun(b_ur), .underrun_cnt(b_cnt)
    );

    assign m_ready = sel ? b_ready : a_ready;
    assign m_bck   = sel ? b_bck   : a_bck;
    assign m_dl    = sel ? b_dl    : a_dl;
    assign m_dr    = sel ? b_dr    : a_dr;
    assign m_ll    = sel ? b_ll    : a_ll;
    assign m_lr    = sel ? b_lr    : a_lr;
    assign m_fs    = sel ? b_fs    : a_fs;
    assign m_busy  = sel ? b_busy  : a_busy;
    assign m_ur    = sel ? b_ur    : a_ur;
    assign m_cnt   = sel ? b_cnt   : a_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_en(input logic v);
        if (sel) en_b = v;
        else     en_a = v;
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (m_ready !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_ready", {31'd0, m_ready}, 32'd1);
    endtask

    // Called at a negedge where in_ready is high; returns just after the capture edge.
    task automatic drive_capture(input logic v, input logic m, input logic [15:0] l, input logic [15:0] r);
        exp_t e;
        check("ready_at_capture", {31'd0, m_ready}, 32'd1);
        in_valid = v;
        mute     = m;
        in_left  = l;
        in_right = r;
        if (v) begin
            held_l = l;
            held_r = r;
        end else if (exp_cnt != 255) begin
            exp_cnt++;
        end
        e.l = m ? 16'h0 : held_l;
        e.r = m ? 16'h0 : held_r;
        sb.push_back(e);
        $display("capture valid=%0b mute=%0b l=%h r=%h -> expect %h/%h", v, m, l, r, e.l, e.r);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mute     = 1'b0;
    endtask

    // Observes one frame of output; ends at the negedge of the next boundary cycle.
    task automatic check_frame(input int drop_at, input int rise_at, input logic expect_next);
        exp_t        e;
        logic [15:0] gl = '0, gr = '0;
        int ll_n = 0, lr_n = 0, ll_first = -1, fs_n = 0, viol = 0, bck_err = 0, tail_err = 0;
        logic prev_dl = 1'b0;
        check("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        repeat (2) @(negedge clk);
        for (int c = 0; c <= fc - 2; c++) begin
            int slot, ph;
            if (c > 0) @(negedge clk);
            if (c + 1 == drop_at) set_en(1'b0);
            if (c + 1 == rise_at) set_en(1'b1);
            slot = c / div;
            ph   = c % div;
            if (c == 0) check("frame_start", {31'd0, m_fs}, 32'd1);
            else        fs_n += int'(m_fs);
            if (slot < 16 && ph == div / 2) begin
                gl[15 - slot] = m_dl;
                gr[15 - slot] = m_dr;
            end
            if (m_ll) begin
                if (ll_n == 0) ll_first = c;
                ll_n++;
            end
            lr_n += int'(m_lr);
            if (m_bck !== (ph >= div / 2)) bck_err++;
            if (c > 0 && m_bck && m_dl !== prev_dl) viol++;
            if (slot >= 16 && (m_dl || m_dr)) tail_err++;
            prev_dl = m_dl;
        end
        $display("frame got %h/%h expect %h/%h latch@%0d x%0d", gl, gr, e.l, e.r, ll_first, ll_n);
        check("data_left", {16'd0, gl}, {16'd0, e.l});
        check("data_right", {16'd0, gr}, {16'd0, e.r});
        check("ll_count", ll_n, div);
        check("ll_slot", ll_first, 16 * div);
        check("lr_count", lr_n, div);
        check("extra_frame_start", fs_n, 0);
        check("bck_pattern", bck_err, 0);
        check("dl_change_bck_high", viol, 0);
        check("tail_zero", tail_err, 0);
        check("boundary_ready", {31'd0, m_ready}, {31'd0, expect_next});
    endtask

    initial begin
        int acc;
        exp_t junk;
        reset_n = 1'b0; en_a = 1'b0; en_b = 1'b0; mute = 1'b0; in_valid = 1'b0;
        in_left = '0; in_right = '0;
        held_l = '0; held_r = '0; exp_cnt = 0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {23'd0, a_ready, a_bck, a_dl, a_dr, a_ll, a_lr, a_fs, a_busy, a_ur}, 32'd0);
        check("reset_cnt", {24'd0, a_cnt}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        en_a = 1'b1;
        check("ready_idle", {31'd0, m_ready}, 32'd0);
        @(negedge clk);
        check("ready_arm_latency", {31'd0, m_ready}, 32'd1);
        check("busy_arm", {31'd0, m_busy}, 32'd1);

        drive_capture(1'b1, 1'b0, 16'hA5C3, 16'h5A3C);
        check_frame(-1, -1, 1'b1);
        drive_capture(1'b1, 1'b0, 16'h1234, 16'h0001);
        check_frame(-1, -1, 1'b1);
        check("no_underrun_yet", {31'd0, m_ur}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive_capture(1'b0, 1'b0, 16'hDEAD, 16'hBEEF);
            check_frame(-1, -1, 1'b1);
        end
        check("underrun_set", {31'd0, m_ur}, 32'd1);
        check("underrun_cnt_3", {24'd0, m_cnt}, 32'd3);

        drive_capture(1'b1, 1'b1, 16'h7FFF, 16'h0003);
        check_frame(-1, -1, 1'b1);
        drive_capture(1'b0, 1'b0, 16'h0000, 16'h0000);
        check_frame(-1, -1, 1'b1);
        check("underrun_cnt_model", {24'd0, m_cnt}, exp_cnt);

        drive_capture(1'b1, 1'b0, 16'h0F0F, 16'hF0F0);
        check_frame(100, 200, 1'b1);
        drive_capture(1'b1, 1'b0, 16'h3C3C, 16'hC3C3);
        check_frame(100, -1, 1'b0);
        @(negedge clk);
        check("idle_after_stop", {31'd0, m_busy}, 32'd0);
        acc = 0;
        repeat (20) begin
            @(negedge clk);
            acc += int'(m_bck | m_dl | m_dr | m_ll | m_lr | m_fs | m_ready);
        end
        check("quiet_in_idle", acc, 0);
        en_a = 1'b1;
        check("ready_before_rearm", {31'd0, m_ready}, 32'd0);
        @(negedge clk);
        check("ready_rearm_latency", {31'd0, m_ready}, 32'd1);

        drive_capture(1'b1, 1'b0, 16'hAAAA, 16'h5555);
        junk = sb.pop_front();
        repeat (501) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midframe_reset_outputs", {24'd0, m_ready, m_bck, m_dl, m_dr, m_ll, m_lr, m_fs, m_busy}, 32'd0);
        check("midframe_reset_underrun", {23'd0, m_ur, m_cnt}, 32'd0);
        held_l = '0; held_r = '0; exp_cnt = 0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {31'd0, m_ready}, 32'd1);
        drive_capture(1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
        check_frame(-1, -1, 1'b1);
        check("underrun_cnt_after_reset", {24'd0, m_cnt}, 32'd1);

        en_a = 1'b0;
        sel = 1'b1; div = 2; fc = 40;
        held_l = '0; held_r = '0; exp_cnt = 0;
        @(negedge clk);
        en_b = 1'b1;
        @(negedge clk);
        check("b_ready_arm", {31'd0, m_ready}, 32'd1);
        drive_capture(1'b1, 1'b0, 16'hA5C3, 16'h5A3C);
        check_frame(-1, -1, 1'b1);
        drive_capture(1'b1, 1'b0, 16'h8001, 16'h7FFE);
        check_frame(-1, -1, 1'b1);
        for (int i = 0; i < 300; i++) begin
            wait_ready(fc + 5);
            drive_capture(1'b0, 1'b0, 16'h0000, 16'h0000);
            junk = sb.pop_front();
        end
        wait_ready(fc + 5);
        check("b_underrun", {31'd0, m_ur}, 32'd1);
        check("b_underrun_cnt_sat", {24'd0, m_cnt}, 32'd255);
        drive_capture(1'b0, 1'b0, 16'h0000, 16'h0000);
        check_frame(-1, -1, 1'b1);
        check("b_cnt_still_sat", {24'd0, m_cnt}, 32'd255);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dac_frame_sequencer.md
# dac_frame_sequencer

Frame scheduler and serializer controller for the stereo serial DAC. Runs on clk_48 and generates the bit clock, MSB-first left/right data and per-channel latch strobes, one frame per output sample. Pulls one stereo sample per frame from the upstream mixer over a valid/ready handshake. Handles underrun, mute and clean start/stop. Sits between the channel-strip output stage and the DAC pins.

## Interface
- DIV, 4: clk_48 cycles per bit slot; even, ≥2.
- FRAME_CYCLES, 1000: clk_48 cycles per frame (48 kHz at 48 MHz); multiple of DIV; FRAME_CYCLES/DIV ≥ WIDTH+2.
- WIDTH, 16: sample width.
- clk_48  in  1  system clock; all logic on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- enable  in  1  run request; level-sensitive.
- mute  in  1  force zero data; sampled at capture.
- in_left, in_right  in  WIDTH  signed sample from upstream.
- in_valid  in  1  sample available.
- in_ready  out  1  capture strobe; transfer when in_valid && in_ready.
- bck  out  1  DAC bit clock.
- DL, DR  out  1  serial data, left/right.
- LL, LR  out  1  latch strobes, left/right.
- frame_start  out  1  one-cycle pulse at the start of each frame.
- busy  out  1  high in ARM or RUN.
- underrun  out  1  sticky; set on missed sample; cleared by reset only.
- underrun_cnt  out  8  saturating count of missed samples.

## Operation
- States: IDLE, ARM, RUN.
- IDLE: all outputs 0; counters held at 0. With enable=1, go to ARM.
- ARM: lasts one cycle; in_ready=1 for capture; next state RUN with cyc=0.
- RUN: cyc counts 0..FRAME_CYCLES-1 and wraps.
  - slot = cyc/DIV; phase = cyc%DIV.
  - At cyc=FRAME_CYCLES-1, in_ready=1 and capture occurs.
  - If enable=0 at that cycle, go to IDLE instead and drop in_ready.
- Capture cycle:
  - in_valid=1: sample register ← {in_left,in_right}.
  - in_valid=0: keep previous sample (zero if none since reset); set underrun; underrun_cnt += 1, saturating at 255.
  - mute=1: shift register loads zeros. A valid sample is still consumed, and the held sample still updates.
- Slots 0..WIDTH-1: DL/DR = bit (WIDTH-1-slot) of left/right.
- Slot WIDTH: DL=DR=0; LL=LR=1.
- Slots WIDTH+1..end: DL=DR=LL=LR=0.
- bck = 1 for phase ≥ DIV/2, else 0; bck runs in all RUN slots.
- frame_start = 1 when cyc=0 in RUN.
- enable deasserted mid-frame: the current frame completes, including its latch, and the state returns to IDLE at the frame boundary. enable reasserted before that boundary cancels the stop.
- Async reset mid-frame: immediate IDLE; outputs and counters go to 0; underrun and underrun_cnt are cleared.

## Timing
- Reset values: in_ready, bck, DL, DR, LL, LR, frame_start, busy, underrun = 0; underrun_cnt = 0.
- DL/DR/LL/LR/bck/frame_start are registered and reflect cyc from the previous cycle: one clk_48 latency, identical for all, so relative alignment is exact.
- DL/DR change only on bck falling edges. Data is stable DIV/2 cycles before each bck rise.
- in_ready is combinational from state/cyc, and high exactly one cycle per frame.
- Capture → first MSB on DL: 2 cycles (capture, cyc=0, output register).
- Enable rise → first in_ready: 1 cycle (IDLE→ARM).
- Frame period: exactly FRAME_CYCLES, with no gap between frames.
- Stop: the last in_ready is at the final boundary before IDLE, not on the terminating boundary itself.

## Test plan
- Reset, enable=1, in_valid=1, L=0xA5C3, R=0x5A3C, defaults:
  - DL shows 1010010111000011 and DR shows 0101101000111100, MSB first, 4 cycles per bit.
  - LL/LR are high for exactly 4 cycles after bit 15.
  - Next frame_start follows 1000 cycles after the first.
- in_valid held low for 3 frames after one valid sample 0x1234/0x0001:
  - The same data repeats 3×.
  - underrun=1 and underrun_cnt=3.
  - 300 misses saturate underrun_cnt at 255.
- mute=1 at a capture with L=0x7FFF:
  - DL=0 for the whole frame; LL still pulses; in_ready handshake completes.
  - The next unmuted frame with in_valid=0 outputs 0x7FFF.
- enable dropped at cyc=100:
  - The frame finishes, including the latch.
  - No in_ready at the boundary; IDLE after it; bck stays 0.
  - Re-enable gives in_ready 1 cycle later.
- reset_n pulsed low at cyc=500 mid-shift: all outputs 0 the same cycle; underrun_cnt=0; restarts via ARM once enable=1.
- DIV=2, FRAME_CYCLES=40: 20 slots; latch in slot 16; continuous frames every 40 cycles.
